// File: rtl/tone_pkg.sv
// Shared types and tables for the tone sequencer: note encodings, pitch and
// volume lookups, FSM states and the built-in song.
package tone_pkg;

  localparam int         NOTE_W    = 5;
  localparam logic [4:0] CODE_REST = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  // Base pitch in Hz for C..B; 0 marks a rest (code 0 and the unused 13..15).
  function automatic logic [31:0] base_freq(input logic [3:0] note);
    case (note)
      4'd1:    return 32'd262;
      4'd2:    return 32'd277;
      4'd3:    return 32'd294;
      4'd4:    return 32'd311;
      4'd5:    return 32'd330;
      4'd6:    return 32'd349;
      4'd7:    return 32'd370;
      4'd8:    return 32'd392;
      4'd9:    return 32'd415;
      4'd10:   return 32'd440;
      4'd11:   return 32'd466;
      4'd12:   return 32'd494;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic is_rest(input logic [NOTE_W-1:0] code);
    return base_freq(code[3:0]) == 32'd0;
  endfunction

  function automatic logic [31:0] note_freq(input logic [NOTE_W-1:0] code);
    return code[4] ? (base_freq(code[3:0]) << 1) : base_freq(code[3:0]);
  endfunction

  // Top step stops at 512 so the generator never exceeds 50% duty.
  function automatic logic [9:0] vol_duty(input logic [2:0] vol);
    case (vol)
      3'd0:    return 10'd0;
      3'd1:    return 10'd64;
      3'd2:    return 10'd128;
      3'd3:    return 10'd192;
      3'd4:    return 10'd256;
      3'd5:    return 10'd320;
      3'd6:    return 10'd384;
      default: return 10'd512;
    endcase
  endfunction

  function automatic logic [NOTE_W-1:0] default_song(input logic [4:0] idx);
    case (idx)
      5'd0:  return 5'd10;  5'd1:  return 5'h11; 5'd2:  return 5'd0;  5'd3:  return 5'd12;
      5'd4:  return 5'd8;   5'd5:  return 5'd10; 5'd6:  return 5'd12; 5'd7:  return 5'h11;
      5'd8:  return 5'h13;  5'd9:  return 5'h11; 5'd10: return 5'd12; 5'd11: return 5'd10;
      5'd12: return 5'd8;   5'd13: return 5'd6;  5'd14: return 5'd5;  5'd15: return 5'd0;
      5'd16: return 5'd1;   5'd17: return 5'd3;  5'd18: return 5'd5;  5'd19: return 5'd6;
      5'd20: return 5'd8;   5'd21: return 5'd10; 5'd22: return 5'd12; 5'd23: return 5'h11;
      5'd24: return 5'h11;  5'd25: return 5'd12; 5'd26: return 5'd10; 5'd27: return 5'd8;
      5'd28: return 5'd6;   5'd29: return 5'd5;  5'd30: return 5'd3;  default: return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// Control inputs and generator-facing outputs of the tone sequencer.
interface tone_sequencer_if;
  logic        start;
  logic        stop;
  logic        pause;
  logic        loop_en;
  logic [2:0]  volume;
  logic [31:0] freq;
  logic [9:0]  duty;
  logic        busy;
  logic        done;
  logic [4:0]  note_idx;

  modport master (
    output start, stop, pause, loop_en, volume,
    input  freq, duty, busy, done, note_idx
  );

  modport slave (
    input  start, stop, pause, loop_en, volume,
    output freq, duty, busy, done, note_idx
  );
endinterface

// File: rtl/tone_sequencer_note_rom.sv
// Song table lookup; indices past the song length read back as rests.
module note_rom
  import tone_pkg::*;
#(
  parameter int SONG_LEN = 32
) (
  input  logic [4:0]        i_idx,
  output logic [NOTE_W-1:0] o_code
);

  assign o_code = ({1'b0, i_idx} < 6'(SONG_LEN)) ? default_song(i_idx) : CODE_REST;

endmodule

// File: rtl/tone_sequencer.sv
// Beat-driven note sequencer feeding frequency/duty to the PWM tone generator.
// Outputs are registered one cycle behind state, index and volume.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int BEAT_DIV       = 12_500_000,
  parameter int SONG_LEN       = 32,
  parameter int BEATS_PER_NOTE = 4,
  parameter int GAP_BEATS      = 1,
  parameter int REST_FREQ      = 1000
) (
  input  logic             clk,
  input  logic             reset,
  tone_sequencer_if.slave  bus
);

  localparam int                CYC_W      = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam int                BEAT_W     = $clog2(BEATS_PER_NOTE);
  localparam logic [CYC_W-1:0]  CYC_LAST   = CYC_W'(BEAT_DIV - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BEATS_PER_NOTE - 1);
  localparam logic [BEAT_W:0]   BEAT_SOUND = (BEAT_W + 1)'(BEATS_PER_NOTE - GAP_BEATS);
  localparam logic [4:0]        NOTE_LAST  = 5'(SONG_LEN - 1);
  localparam logic [31:0]       REST_F     = 32'(REST_FREQ);

  state_t            r_state;
  logic [CYC_W-1:0]  r_cyc_cnt;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [4:0]        r_note_idx;
  logic [31:0]       r_freq;
  logic [9:0]        r_duty;
  logic              r_busy;
  logic              r_done;

  logic [NOTE_W-1:0] w_code;
  logic              w_beat_tick;
  logic              w_audible;

  note_rom #(.SONG_LEN(SONG_LEN)) u_rom (
    .i_idx  (r_note_idx),
    .o_code (w_code)
  );

  assign w_beat_tick = (r_state == ST_PLAY) && (r_cyc_cnt == CYC_LAST);
  // The trailing gap beats of every note are silent to articulate repeats.
  assign w_audible   = (r_state == ST_PLAY) && !is_rest(w_code) &&
                       ({1'b0, r_beat_cnt} < BEAT_SOUND);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cyc_cnt  <= '0;
      r_beat_cnt <= '0;
      r_note_idx <= '0;
      r_freq     <= REST_F;
      r_duty     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_freq <= w_audible ? note_freq(w_code) : REST_F;
      r_duty <= w_audible ? vol_duty(bus.volume) : 10'd0;
      case (r_state)
        ST_PLAY, ST_PAUSED: begin
          if (bus.stop) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_cyc_cnt  <= '0;
            r_beat_cnt <= '0;
            r_note_idx <= '0;
          end else if (r_state == ST_PAUSED) begin
            if (!bus.pause) r_state <= ST_PLAY;
          end else begin
            if (bus.pause) r_state <= ST_PAUSED;
            r_cyc_cnt <= w_beat_tick ? '0 : r_cyc_cnt + 1'b1;
            if (w_beat_tick) begin
              if (r_beat_cnt == BEAT_LAST) begin
                r_beat_cnt <= '0;
                // Natural completion overrides a simultaneous pause request.
                if (r_note_idx == NOTE_LAST) begin
                  r_note_idx <= '0;
                  if (!bus.loop_en) begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                  end
                end else begin
                  r_note_idx <= r_note_idx + 1'b1;
                end
              end else begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
              end
            end
          end
        end
        default: begin
          r_cyc_cnt  <= '0;
          r_beat_cnt <= '0;
          r_note_idx <= '0;
          if (bus.start && !bus.stop) begin
            r_state <= ST_PLAY;
            r_busy  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.freq     = r_freq;
  assign bus.duty     = r_duty;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.note_idx = r_note_idx;

endmodule
